// File: rtl/vga_gen.sv
// vga_gen: 640x480@60 VGA timing and colour-bar test-pattern generator.
// Latency: outputs are registered 1 clk after the counter values they decode.
// Backpressure: none; free-running, and each pixel is held for 2 clk (25 MHz pixel rate from 50 MHz).
//
// Ports:
//   clk                 50 MHz system clock, rising edge
//   RSTn                asynchronous reset, ACTIVE-HIGH despite the name (1 = reset)
//   hsync, vsync        negative-polarity syncs
//   hvalid, vvalid      visible-region qualifiers
//   r, g, b             1-bit colour, 0 outside the visible region
// Optional feature macro: VGA_GRID_EN (white 32-pixel grid over the bars).
module vga_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic clk,
    input  logic RSTn,
    output logic hsync,
    output logic vsync,
    output logic hvalid,
    output logic vvalid,
    output logic r,
    output logic g,
    output logic b
);

    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
    // Eight equal bars across the visible width.
    localparam logic [10:0] BAR_W   = 11'(H_ACTIVE / 8);

    logic        r_phase;
    logic [10:0] r_hcnt;
    logic [10:0] r_vcnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hvalid;
    logic        r_vvalid;
    logic [2:0]  r_rgb;

    logic        w_hvalid;
    logic        w_vvalid;
    logic        w_hsync;
    logic        w_vsync;
    logic [10:0] w_bar;
    logic [2:0]  w_rgb;

    // Pixel counters advance only on the second clk of each pixel.
    always_ff @(posedge clk or posedge RSTn) begin
        if (RSTn) begin
            r_phase <= 1'b0;
            r_hcnt  <= 11'd0;
            r_vcnt  <= 11'd0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                if (r_hcnt == H_TOTAL - 11'd1) begin
                    r_hcnt <= 11'd0;
                    if (r_vcnt == V_TOTAL - 11'd1) begin
                        r_vcnt <= 11'd0;
                    end else begin
                        r_vcnt <= r_vcnt + 11'd1;
                    end
                end else begin
                    r_hcnt <= r_hcnt + 11'd1;
                end
            end
        end
    end

    // Decode of the current counter values.
    always_comb begin
        w_hvalid = (r_hcnt < H_ACT);
        w_vvalid = (r_vcnt < V_ACT);
        w_hsync  = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
        w_vsync  = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
        w_bar    = r_hcnt / BAR_W;
        w_rgb    = 3'd0;
        if (w_hvalid && w_vvalid) begin
            // Bar 0 is white (111) counting down to bar 7 black (000).
            w_rgb = 3'd7 - w_bar[2:0];
`ifdef VGA_GRID_EN
            if ((r_hcnt[4:0] == 5'd0) || (r_vcnt[4:0] == 5'd0)) begin
                w_rgb = 3'd7;
            end
`else
`endif
        end
    end

    always_ff @(posedge clk or posedge RSTn) begin
        if (RSTn) begin
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_hvalid <= 1'b0;
            r_vvalid <= 1'b0;
            r_rgb    <= 3'd0;
        end else begin
            r_hsync  <= w_hsync;
            r_vsync  <= w_vsync;
            r_hvalid <= w_hvalid;
            r_vvalid <= w_vvalid;
            r_rgb    <= w_rgb;
        end
    end

    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign hvalid = r_hvalid;
    assign vvalid = r_vvalid;
    assign r      = r_rgb[2];
    assign g      = r_rgb[1];
    assign b      = r_rgb[0];

endmodule

// File: tb/tb_vga_gen.sv
// tb_vga_gen: checks vga_gen against a pixel-position reference model.
// Two instances: full 640x480 timing (lines) and a shrunken mode (whole frames).
// Random asynchronous resets are applied mid-frame.
`timescale 1ns/1ps
module tb_vga_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic a_hs, a_vs, a_hv, a_vv, a_r, a_g, a_b;
    logic b_hs, b_vs, b_hv, b_vv, b_r, b_g, b_b;

    always #10 clk = ~clk;

    vga_gen u_full (
        .clk(clk), .RSTn(rst),
        .hsync(a_hs), .vsync(a_vs), .hvalid(a_hv), .vvalid(a_vv),
        .r(a_r), .g(a_g), .b(a_b)
    );

    vga_gen #(
        .H_ACTIVE(80), .H_FP(6), .H_SYNC(8), .H_BP(10),
        .V_ACTIVE(40), .V_FP(3), .V_SYNC(2), .V_BP(4)
    ) u_small (
        .clk(clk), .RSTn(rst),
        .hsync(b_hs), .vsync(b_vs), .hvalid(b_hv), .vvalid(b_vv),
        .r(b_r), .g(b_g), .b(b_b)
    );

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
    } exp_t;

    exp_t q[$];
    int   k      = 0;
    int   errors = 0;
    int   checks = 0;

    localparam logic [6:0] RESET_VAL = 7'b1100000;

    // Output seen at edge n (n = 0 is the first edge after reset) is pixel
    // n/2 in raster order: {hsync, vsync, hvalid, vvalid, r, g, b}.
    function automatic logic [6:0] model(int n, int ha, int hf, int hs, int hb,
                                         int va, int vf, int vs, int vb);
        int ht;
        int vt;
        int p;
        int h;
        int v;
        logic hv;
        logic vv;
        logic hsy;
        logic vsy;
        logic [2:0] c;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        p   = n / 2;
        h   = p % ht;
        v   = (p / ht) % vt;
        hv  = (h < ha);
        vv  = (v < va);
        hsy = !(h >= ha + hf && h < ha + hf + hs);
        vsy = !(v >= va + vf && v < va + vf + vs);
        c   = 3'd0;
        if (hv && vv) begin
            c = 3'(7 - h / (ha / 8));
`ifdef VGA_GRID_EN
            if (h % 32 == 0 || v % 32 == 0) c = 3'd7;
`else
`endif
        end
        return {hsy, vsy, hv, vv, c};
    endfunction

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got {hs,vs,hv,vv,rgb}=%b expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference model: one expected output per active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                k = 0;
            end else begin
                q.push_back('{model(k, 640, 16, 96, 48, 480, 10, 2, 33),
                              model(k, 80, 6, 8, 10, 40, 3, 2, 4)});
                k++;
            end
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                chk("reset_full",  {a_hs, a_vs, a_hv, a_vv, a_r, a_g, a_b}, RESET_VAL);
                chk("reset_small", {b_hs, b_vs, b_hv, b_vv, b_r, b_g, b_b}, RESET_VAL);
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL no_expected at %0t: got empty queue, required one entry", $time);
            end else begin
                e = q.pop_front();
                chk("pixel_full",  {a_hs, a_vs, a_hv, a_vv, a_r, a_g, a_b}, e.a);
                chk("pixel_small", {b_hs, b_vs, b_hv, b_vv, b_r, b_g, b_b}, e.b);
            end
        end
    end

    // Stimulus: power-on reset, long run, random async mid-frame resets, long run.
    initial begin
        rst = 1'b1;
        #25 rst = 1'b0;
        repeat (22000) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(200, 3000)) @(posedge clk);
            #($urandom_range(2, 8));
            rst = 1'b1;
            #1;
            chk("async_reset_full",  {a_hs, a_vs, a_hv, a_vv, a_r, a_g, a_b}, RESET_VAL);
            chk("async_reset_small", {b_hs, b_vs, b_hv, b_vv, b_r, b_g, b_b}, RESET_VAL);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #5 rst = 1'b0;
        end
        repeat (12000) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
